// File: rtl/edge_cnt_pkg.sv
// Shared constants for the edge counter array: edge_mode encoding and arming length.
package edge_cnt_pkg;

   localparam logic [1:0] EDGE_FALL = 2'b00;
   localparam logic [1:0] EDGE_RISE = 2'b01;
   localparam logic [1:0] EDGE_BOTH = 2'b10;
   localparam logic [1:0] EDGE_OFF  = 2'b11;

   // Clocks of suppressed detection after reset release; covers the synchroniser fill.
   function automatic int unsigned arm_len(input int unsigned sync_stages);
      return sync_stages + 1;
   endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchroniser, edge detect, counter, toggle output and sticky overflow.
module edge_chan
   import edge_cnt_pkg::*;
#(
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic [1:0]       edge_mode,
   input  logic             armed,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             edge_pulse,
   output logic             to_osc,
   output logic             overflow
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   s;
   logic                   hit;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   pulse_q, pulse_d;
   logic                   tog_q, tog_d;
   logic                   ovf_q, ovf_d;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      hit = 1'b0;
      case (edge_mode)
         EDGE_FALL: hit = prev_q & ~s;
         EDGE_RISE: hit = ~prev_q & s;
         EDGE_BOTH: hit = prev_q ^ s;
         EDGE_OFF:  hit = 1'b0;
         default:   hit = 1'b0;
      endcase
   end

   // clr wins over a same-cycle edge; the toggle output is left alone by clr.
   always_comb begin
      count_d = count_q;
      pulse_d = 1'b0;
      tog_d   = tog_q;
      ovf_d   = ovf_q;
      if (clr) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (hit && armed) begin
         count_d = count_q + CNT_W'(1);
         pulse_d = 1'b1;
         tog_d   = ~tog_q;
         if (&count_q) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         count_q <= '0;
         pulse_q <= 1'b0;
         tog_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q  <= s;
         count_q <= count_d;
         pulse_q <= pulse_d;
         tog_q   <= tog_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count      = count_q;
   assign edge_pulse = pulse_q;
   assign to_osc     = tog_q;
   assign overflow   = ovf_q;

endmodule

// File: rtl/edge_counter_array.sv
// Multi-channel edge counter with arming after reset, channel select/LED view and clock divider.
module edge_counter_array
   import edge_cnt_pkg::*;
#(
   parameter int unsigned NCH         = 4,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DIV_W       = 8,
   localparam int unsigned SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             pll_inst1_CLKOUT0,
   input  logic             BTN0,
   input  logic [NCH-1:0]   data_in,
   input  logic [1:0]       edge_mode,
   input  logic             clr,
   input  logic [DIV_W-1:0] div_ratio,
   input  logic [SEL_W-1:0] sel,
   output logic [CNT_W-1:0] count_out,
   output logic [3:0]       LED,
   output logic [NCH-1:0]   edge_pulse,
   output logic [NCH-1:0]   to_osc,
   output logic [NCH-1:0]   overflow,
   output logic             clk_out
);

   localparam int unsigned ARM_LEN = arm_len(SYNC_STAGES);
   localparam int unsigned ARM_W   = $clog2(ARM_LEN + 1);

   logic [ARM_W-1:0] arm_q;
   logic             armed;
   logic [CNT_W-1:0] cnt [NCH];
   logic [DIV_W-1:0] div_cnt_q;
   logic             clk_out_q;

   assign armed = (arm_q == ARM_W'(ARM_LEN));

   always_ff @(posedge pll_inst1_CLKOUT0 or negedge BTN0) begin
      if (!BTN0) begin
         arm_q <= '0;
      end else if (!armed) begin
         arm_q <= arm_q + ARM_W'(1);
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      edge_chan #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .clk        (pll_inst1_CLKOUT0),
         .rst_n      (BTN0),
         .din        (data_in[g]),
         .edge_mode  (edge_mode),
         .armed      (armed),
         .clr        (clr),
         .count      (cnt[g]),
         .edge_pulse (edge_pulse[g]),
         .to_osc     (to_osc[g]),
         .overflow   (overflow[g])
      );
   end

   // Out-of-range selects fall through to zero.
   always_comb begin
      count_out = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (sel == SEL_W'(i)) count_out = cnt[i];
      end
   end

   always_comb begin
      LED = 4'hF;
      for (int i = 0; i < 4; i++) LED[i] = ~count_out[3-i];
   end

   always_ff @(posedge pll_inst1_CLKOUT0 or negedge BTN0) begin
      if (!BTN0) begin
         div_cnt_q <= '0;
         clk_out_q <= 1'b0;
      end else if (div_cnt_q >= div_ratio) begin
         div_cnt_q <= '0;
         clk_out_q <= ~clk_out_q;
      end else begin
         div_cnt_q <= div_cnt_q + DIV_W'(1);
      end
   end

   assign clk_out = clk_out_q;

endmodule
